// File: rtl/keccak_sponge_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keccak_sponge_ctrl : SHA3 sponge sequencer (pad10*1, 0x06 suffix) for one
// single-cycle keccak core. Revision 1.0
// ---------------------------------------------------------------------------
module keccak_sponge_ctrl #(
  parameter int D = 224,
  parameter int B = 1600,
  parameter int R = B - 2*D,
  parameter int W = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [W-1:0]             in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic [$clog2(W/8+1)-1:0] in_bytes,
  output logic                     in_ready,
  output logic [R-1:0]             core_message,
  output logic                     core_enable,
  output logic                     core_clear,
  input  logic [D-1:0]             core_digest,
  output logic [D-1:0]             digest,
  output logic                     digest_valid,
  input  logic                     digest_ready,
  output logic                     busy
);

  localparam int c_NW = R / W;
  localparam int c_NB = W / 8;
  localparam int c_RB = R / 8;
  localparam int c_CW = $clog2(c_NW);
  localparam int c_IW = $clog2(c_RB);
  localparam int c_BW = $clog2(W/8 + 1);
  localparam logic [c_CW-1:0] c_LASTW = c_CW'(c_NW - 1);
  localparam logic [c_BW-1:0] c_FULLB = c_BW'(c_NB);
  localparam logic [R-1:0] c_PAD_ONLY = {8'h06, {(R-16){1'b0}}, 8'h80};

  localparam logic [2:0] c_IDLE        = 3'd0;
  localparam logic [2:0] c_CLEAR       = 3'd1;
  localparam logic [2:0] c_FILL        = 3'd2;
  localparam logic [2:0] c_ABSORB      = 3'd3;
  localparam logic [2:0] c_PAD         = 3'd4;
  localparam logic [2:0] c_ABSORB_LAST = 3'd5;
  localparam logic [2:0] c_ABSORB_FIN  = 3'd6;
  localparam logic [2:0] c_OUT         = 3'd7;

  logic [2:0]      r_state, w_next;
  logic [c_CW-1:0] r_count;
  logic [R-1:0]    r_buf;
  logic [c_IW-1:0] r_pad_idx;
  logic            r_exact;

  logic            w_accept;
  logic [c_BW-1:0] w_nb;
  logic [W-1:0]    w_word;
  logic [R-1:0]    w_padded;

  assign w_accept = (r_state == c_FILL) && in_valid;
  assign w_nb     = (in_bytes > c_FULLB) ? c_FULLB : in_bytes;

  // Tail bytes beyond the valid count are forced to zero before packing.
  always_comb begin
    w_word = in_data;
    for (int i = 0; i < c_NB; i++) begin
      if (in_last && (i >= int'(w_nb)))
        w_word[W-1-8*i -: 8] = 8'h00;
    end
  end

  always_comb begin
    w_padded = r_buf;
    for (int j = 0; j < c_RB; j++) begin
      if (j == int'(r_pad_idx))
        w_padded[R-1-8*j -: 8] = w_padded[R-1-8*j -: 8] | 8'h06;
    end
    w_padded[7:0] = w_padded[7:0] | 8'h80;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:        w_next = c_CLEAR;
      c_CLEAR:       w_next = c_FILL;
      c_FILL: begin
        if (w_accept) begin
          if (in_last)                 w_next = c_PAD;
          else if (r_count == c_LASTW) w_next = c_ABSORB;
        end
      end
      c_ABSORB:      w_next = c_FILL;
      c_PAD:         w_next = r_exact ? c_ABSORB_LAST : c_ABSORB_FIN;
      c_ABSORB_LAST: w_next = c_ABSORB_FIN;
      c_ABSORB_FIN:  w_next = c_OUT;
      c_OUT:         w_next = digest_ready ? c_CLEAR : c_OUT;
      default:       w_next = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count   <= '0;
      r_buf     <= '0;
      r_pad_idx <= '0;
      r_exact   <= 1'b0;
    end else begin
      case (r_state)
        c_CLEAR, c_ABSORB: begin
          r_count <= '0;
          r_buf   <= '0;
        end
        c_FILL: begin
          if (w_accept) begin
            for (int k = 0; k < c_NW; k++) begin
              if (r_count == c_CW'(k))
                r_buf[R-1-k*W -: W] <= w_word;
            end
            if (in_last) begin
              r_pad_idx <= c_IW'(int'(r_count) * c_NB + int'(w_nb));
              r_exact   <= (r_count == c_LASTW) && (w_nb == c_FULLB);
            end else if (r_count != c_LASTW) begin
              r_count <= r_count + c_CW'(1);
            end
          end
        end
        // An exactly full final block is absorbed unchanged first.
        c_PAD:         if (!r_exact) r_buf <= w_padded;
        c_ABSORB_LAST: r_buf <= c_PAD_ONLY;
        default: ;
      endcase
    end
  end

  // The core is idle during OUT, so its digest is stable while it is held.
  always_comb begin
    in_ready     = (r_state == c_FILL);
    core_clear   = (r_state == c_CLEAR);
    core_enable  = (r_state == c_ABSORB) || (r_state == c_ABSORB_LAST) ||
                   (r_state == c_ABSORB_FIN);
    core_message = core_enable ? r_buf : '0;
    digest_valid = (r_state == c_OUT);
    digest       = digest_valid ? core_digest : '0;
    busy         = (r_state != c_IDLE) && !((r_state == c_FILL) && (r_count == '0));
  end

endmodule
`default_nettype wire
